cca_pixel_transform: RTL

- Downstream consumer of the Bradford chromatic-adaptation stage.
- Latches the 3x3 Q16.16 compensation matrix whenever matrix_valid pulses, and applies it to a streaming RGB888 pixel bus through a 3-stage pipeline with saturation.
- Matrix updates are double-buffered so a new matrix only takes effect at a frame boundary.
- Sits between the video input path and the display output path.

---
 rtl/cca_pkg.sv | 46 ++++
 rtl/cca_pixel_transform_if.sv | 13 +
 rtl/cca_row_mac.sv | 51 +++++
 rtl/cca_pixel_transform.sv | 89 ++++++++
 4 files changed

// File: rtl/cca_pkg.sv
// Shared types and constants for the colour-compensation datapath.
package cca_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned COEF_W    = 32;
  localparam int unsigned FRAC_BITS = 16;
  localparam int unsigned N_CH      = 3;

  // Product of a signed coefficient and a zero-extended channel, and a 3-term sum.
  localparam int unsigned PROD_W = COEF_W + PIX_W + 1;
  localparam int unsigned SUM_W  = PROD_W + 2;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0]  acc_t;

  // [row][col]; packed so that element k = row*3+col sits at bits [k*32 +: 32].
  typedef coef_t [N_CH-1:0][N_CH-1:0] coef_mat_t;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } pixel_t;

  localparam coef_t Q_ONE  = 32'sh0001_0000;
  localparam coef_t Q_HALF = 32'sh0000_8000;

  localparam logic [N_CH*N_CH*COEF_W-1:0] IDENTITY_MATRIX =
    {Q_ONE, {3{32'h0}}, Q_ONE, {3{32'h0}}, Q_ONE};

  localparam acc_t PIX_MAX = acc_t'((1 << PIX_W) - 1);

  // Drop the fractional bits of a rounded accumulator and clamp to the pixel range.
  function automatic logic [PIX_W-1:0] sat_pixel(input acc_t acc);
    acc_t shifted;
    shifted = acc >>> FRAC_BITS;
    if (shifted[SUM_W-1])
      sat_pixel = '0;
    else if (shifted > PIX_MAX)
      sat_pixel = '1;
    else
      sat_pixel = PIX_W'(shifted);
  endfunction

endpackage

// File: rtl/cca_pixel_transform_if.sv
// Valid/ready RGB pixel stream with start-of-frame marker.
interface cca_pixel_transform_if;
  import cca_pkg::*;

  pixel_t pixel;
  logic   sof;
  logic   valid;
  logic   ready;

  modport master (output pixel, output sof, output valid, input ready);
  modport slave  (input pixel, input sof, input valid, output ready);

endinterface

// File: rtl/cca_row_mac.sv
// One output channel: 3 products, rounded sum, shift and clamp over three stages.
module cca_row_mac
  import cca_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            in_valid,
  input  coef_t [N_CH-1:0]                coef,
  input  logic  [N_CH-1:0][PIX_W-1:0]     ch,
  output logic                            out_valid,
  output logic  [PIX_W-1:0]               out_ch
);

  prod_t prod_q [N_CH];
  acc_t  acc_q;
  logic  s1_valid;
  logic  s2_valid;

  // Stage valids advance together under the global enable; bubbles pass through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
    end
  end

  // Data registers only load for valid beats so the output holds between pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < int'(N_CH); c++) prod_q[c] <= '0;
      acc_q  <= '0;
      out_ch <= '0;
    end else if (en) begin
      if (in_valid) begin
        for (int c = 0; c < int'(N_CH); c++)
          prod_q[c] <= prod_t'(coef[c]) * prod_t'($signed({1'b0, ch[c]}));
      end
      if (s1_valid)
        acc_q <= acc_t'(prod_q[0]) + acc_t'(prod_q[1]) + acc_t'(prod_q[2]) + acc_t'(Q_HALF);
      if (s2_valid)
        out_ch <= sat_pixel(acc_q);
    end
  end

endmodule

// File: rtl/cca_pixel_transform.sv
// Applies a double-buffered 3x3 Q16.16 colour matrix to an RGB888 stream.
module cca_pixel_transform
  import cca_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_CH*N_CH*COEF_W-1:0]     comp_matrix,
  input  logic                            matrix_valid,
  cca_pixel_transform_if.slave            in_bus,
  cca_pixel_transform_if.master           out_bus,
  output logic                            matrix_pending
);

  coef_mat_t active_q;
  coef_mat_t pending_q;
  coef_mat_t eff_mat_c;
  logic      en_c;
  logic      accept_c;
  logic      promote_c;
  logic      sof1_q;
  logic      sof2_q;
  logic      sof3_q;

  logic [N_CH-1:0]            row_valid;
  logic [N_CH-1:0][PIX_W-1:0] row_out;
  logic [N_CH-1:0][PIX_W-1:0] ch_c;

  // Whole pipeline stalls only when a presented output is not taken.
  assign en_c         = !out_bus.valid || out_bus.ready;
  assign in_bus.ready = en_c;
  assign accept_c     = in_bus.valid && en_c;
  assign promote_c    = accept_c && in_bus.sof && matrix_pending;

  // A promoting sof pixel already uses the matrix it promotes.
  assign eff_mat_c = promote_c ? pending_q : active_q;
  assign ch_c      = {in_bus.pixel.b, in_bus.pixel.g, in_bus.pixel.r};

  // Pending buffer captures every strobe; active buffer swaps only at an accepted sof.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q       <= coef_mat_t'(IDENTITY_MATRIX);
      pending_q      <= coef_mat_t'(IDENTITY_MATRIX);
      matrix_pending <= 1'b0;
    end else begin
      if (promote_c)
        active_q <= pending_q;
      if (matrix_valid) begin
        pending_q      <= coef_mat_t'(comp_matrix);
        matrix_pending <= 1'b1;
      end else if (promote_c) begin
        matrix_pending <= 1'b0;
      end
    end
  end

  // Start-of-frame marker travels alongside the pixel data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sof1_q <= 1'b0;
      sof2_q <= 1'b0;
      sof3_q <= 1'b0;
    end else if (en_c) begin
      sof1_q <= accept_c && in_bus.sof;
      sof2_q <= sof1_q;
      if (row_valid[0] == 1'b0 || sof2_q || !sof2_q)
        sof3_q <= sof2_q;
    end
  end

  // One multiply-accumulate lane per output channel (row 0 = R).
  for (genvar r = 0; r < int'(N_CH); r++) begin : g_row
    cca_row_mac u_row (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en_c),
      .in_valid  (accept_c),
      .coef      (eff_mat_c[r]),
      .ch        (ch_c),
      .out_valid (row_valid[r]),
      .out_ch    (row_out[r])
    );
  end

  // All lanes share enable and valid, so their valids are identical.
  assign out_bus.valid = &row_valid;
  assign out_bus.sof   = sof3_q;
  assign out_bus.pixel = pixel_t'({row_out[0], row_out[1], row_out[2]});

endmodule
